text_render_pipe: RTL and testbench

//  Parametrised text-mode pixel renderer between the VGA timing generator and the colour

---
 rtl/text_render_pipe.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_text_render_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_render_pipe.sv
// text_render_pipe
//   Text-mode pixel renderer. Each visible pixel coordinate is mapped to a screen-buffer
//   cell (with hardware row scroll). The cell and its glyph line are then fetched from
//   external synchronous memories. Attribute blink and a blinking underline cursor are
//   applied, and a 4-bit palette index is produced with a fixed latency of 4 cycles.
//
// Ports
//   i_clk, i_rst            pixel clock, asynchronous active-high reset
//   i_pix_valid/x/y         pixel coordinate stream, one pixel per cycle
//   i_frame_start           one-cycle pulse per frame; advances blink, loads scroll shadow
//   i_scroll_row            buffer row shown on screen row 0
//   i_cursor_en/col/row     underline cursor position (screen coordinates)
//   o_char_addr/i_char_data screen-buffer read port; data one cycle after address
//   o_font_addr/i_font_data font read port ({code, line}); data one cycle after address
//   o_out_valid/o_color_index  rendered pixel
//
// Timing for a pixel sampled at E0:
//   E0 stage A: coordinate decode, scroll add, cursor match
//   E1 stage B: o_char_addr registered
//   E2 stage C: buffer memory presents char_data; font address is formed from it
//   E3 stage D: attribute captured, font memory presents font_data
//   E4        : colour registered
module text_render_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = 32,
  parameter int CURSOR_LINES = 2,
  parameter int ATTR_BLINK   = 1,
  localparam int AW          = $clog2(ROWS),
  localparam int CW          = $clog2(COLS),
  localparam int BW          = $clog2(COLS * ROWS),
  localparam int FHL         = $clog2(FONT_H),
  localparam int FAW         = 8 + FHL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic [10:0]       i_pix_x,
  input  logic [10:0]       i_pix_y,
  input  logic              i_frame_start,
  input  logic [AW-1:0]     i_scroll_row,
  input  logic              i_cursor_en,
  input  logic [CW-1:0]     i_cursor_col,
  input  logic [AW-1:0]     i_cursor_row,
  output logic [BW-1:0]     o_char_addr,
  input  logic [15:0]       i_char_data,
  output logic [FAW-1:0]    o_font_addr,
  input  logic [FONT_W-1:0] i_font_data,
  output logic              o_out_valid,
  output logic [3:0]        o_color_index
);

  localparam int FWL       = $clog2(FONT_W);
  localparam int FCW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // First glyph line covered by the cursor; FONT_H when the cursor has no lines.
  localparam int CUR_FIRST = (CURSOR_LINES >= FONT_H) ? 0 : FONT_H - CURSOR_LINES;

  // Frame counter, blink phase and scroll shadow
  logic [FCW-1:0] r_frame_cnt;
  logic           r_blink_phase;
  logic [AW-1:0]  r_shadow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_shadow      <= '0;
    end else if (i_frame_start) begin
      if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      // Out-of-range scroll values fall back to no scroll.
      if ({1'b0, i_scroll_row} >= (AW + 1)'(ROWS)) begin
        r_shadow <= '0;
      end else begin
        r_shadow <= i_scroll_row;
      end
    end
  end

  // Stage A decode (combinational on the raw inputs)
  logic [10:0]    w_col;
  logic [10:0]    w_srow;
  logic           w_in_area;
  logic [AW:0]    w_row_sum;
  logic [AW-1:0]  w_buf_row;
  logic [FHL-1:0] w_line;
  logic [FWL-1:0] w_xbit;
  logic           w_cursor_hit;

  assign w_col     = i_pix_x >> FWL;
  assign w_srow    = i_pix_y >> FHL;
  assign w_in_area = (w_col < 11'(COLS)) && (w_srow < 11'(ROWS));
  assign w_line    = i_pix_y[FHL-1:0];
  assign w_xbit    = i_pix_x[FWL-1:0];

  // Uses the shadow value from before this edge, so a pixel coinciding with
  // frame_start still sees the previous frame's scroll.
  assign w_row_sum = {1'b0, w_srow[AW-1:0]} + {1'b0, r_shadow};
  assign w_buf_row = (w_row_sum >= (AW + 1)'(ROWS)) ? AW'(w_row_sum - (AW + 1)'(ROWS))
                                                   : w_row_sum[AW-1:0];

  assign w_cursor_hit = i_cursor_en &&
                        (w_col == 11'(i_cursor_col)) &&
                        (w_srow == 11'(i_cursor_row)) &&
                        ({1'b0, w_line} >= (FHL + 1)'(CUR_FIRST));

  // Stage A registers
  logic           r_a_valid;
  logic           r_a_in_area;
  logic [CW-1:0]  r_a_col;
  logic [AW-1:0]  r_a_buf_row;
  logic [FHL-1:0] r_a_line;
  logic [FWL-1:0] r_a_xbit;
  logic           r_a_cursor;
  logic           r_a_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_valid   <= 1'b0;
      r_a_in_area <= 1'b0;
      r_a_col     <= '0;
      r_a_buf_row <= '0;
      r_a_line    <= '0;
      r_a_xbit    <= '0;
      r_a_cursor  <= 1'b0;
      r_a_phase   <= 1'b0;
    end else begin
      r_a_valid   <= i_pix_valid;
      r_a_in_area <= w_in_area;
      r_a_col     <= w_col[CW-1:0];
      r_a_buf_row <= w_buf_row;
      r_a_line    <= w_line;
      r_a_xbit    <= w_xbit;
      r_a_cursor  <= w_cursor_hit;
      r_a_phase   <= r_blink_phase;
    end
  end

  // Stage B: buffer address
  logic [BW-1:0]  w_char_addr;
  logic [BW-1:0]  r_char_addr;
  logic           r_b_valid;
  logic           r_b_in_area;
  logic [FHL-1:0] r_b_line;
  logic [FWL-1:0] r_b_xbit;
  logic           r_b_cursor;
  logic           r_b_phase;

  assign w_char_addr = (r_a_valid && r_a_in_area)
                       ? BW'(r_a_buf_row) * BW'(COLS) + BW'(r_a_col)
                       : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_char_addr <= '0;
      r_b_valid   <= 1'b0;
      r_b_in_area <= 1'b0;
      r_b_line    <= '0;
      r_b_xbit    <= '0;
      r_b_cursor  <= 1'b0;
      r_b_phase   <= 1'b0;
    end else begin
      r_char_addr <= w_char_addr;
      r_b_valid   <= r_a_valid;
      r_b_in_area <= r_a_in_area;
      r_b_line    <= r_a_line;
      r_b_xbit    <= r_a_xbit;
      r_b_cursor  <= r_a_cursor;
      r_b_phase   <= r_a_phase;
    end
  end

  assign o_char_addr = r_char_addr;

  // Stage C: char_data is the buffer memory's output register; the font address
  // is taken straight from it so the font read happens in the same slot.
  logic           r_c_valid;
  logic           r_c_in_area;
  logic [FHL-1:0] r_c_line;
  logic [FWL-1:0] r_c_xbit;
  logic           r_c_cursor;
  logic           r_c_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c_valid   <= 1'b0;
      r_c_in_area <= 1'b0;
      r_c_line    <= '0;
      r_c_xbit    <= '0;
      r_c_cursor  <= 1'b0;
      r_c_phase   <= 1'b0;
    end else begin
      r_c_valid   <= r_b_valid;
      r_c_in_area <= r_b_in_area;
      r_c_line    <= r_b_line;
      r_c_xbit    <= r_b_xbit;
      r_c_cursor  <= r_b_cursor;
      r_c_phase   <= r_b_phase;
    end
  end

  assign o_font_addr = {i_char_data[7:0], r_c_line};

  // Stage D: attribute held alongside the font fetch
  logic [7:0]     r_d_attr;
  logic           r_d_valid;
  logic           r_d_in_area;
  logic [FWL-1:0] r_d_xbit;
  logic           r_d_cursor;
  logic           r_d_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d_attr    <= '0;
      r_d_valid   <= 1'b0;
      r_d_in_area <= 1'b0;
      r_d_xbit    <= '0;
      r_d_cursor  <= 1'b0;
      r_d_phase   <= 1'b0;
    end else begin
      r_d_attr    <= i_char_data[15:8];
      r_d_valid   <= r_c_valid;
      r_d_in_area <= r_c_in_area;
      r_d_xbit    <= r_c_xbit;
      r_d_cursor  <= r_c_cursor;
      r_d_phase   <= r_c_phase;
    end
  end

  // Colour resolve
  logic [FWL-1:0] w_bit_idx;
  logic           w_bit;
  logic [3:0]     w_fg;
  logic [3:0]     w_bg;
  logic           w_blink;
  logic [3:0]     w_color;

  assign w_bit_idx = FWL'(FONT_W - 1) - r_d_xbit;
  assign w_bit     = i_font_data[w_bit_idx];

  always_comb begin
    w_fg    = r_d_attr[3:0];
    w_bg    = r_d_attr[7:4];
    w_blink = 1'b0;
    if (ATTR_BLINK != 0) begin
      w_bg    = {1'b0, r_d_attr[6:4]};
      w_blink = r_d_attr[7] && r_d_phase;
    end

    w_color = w_bg;
    if (!r_d_in_area) begin
      w_color = 4'd0;
    end else if (r_d_cursor && !r_d_phase) begin
      // Visible cursor beats both the glyph and attribute blink.
      w_color = w_fg;
    end else if (w_bit) begin
      w_color = w_blink ? w_bg : w_fg;
    end
  end

  logic       r_out_valid;
  logic [3:0] r_color;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_color     <= '0;
    end else begin
      r_out_valid <= r_d_valid;
      r_color     <= r_d_valid ? w_color : 4'd0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_color_index = r_color;

endmodule

// File: tb/tb_text_render_pipe.sv
// Bench for text_render_pipe: behavioural memories, a reference model computed from the
// cell/glyph rules directly, directed steps followed by randomized pixel streams.
module tb_text_render_pipe;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam int BLINK  = 32;
  localparam int CURL   = 2;
  localparam int AW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int BW     = $clog2(COLS * ROWS);
  localparam int FAW    = 8 + $clog2(FONT_H);

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic [10:0]       pix_x;
  logic [10:0]       pix_y;
  logic              frame_start;
  logic [AW-1:0]     scroll_row;
  logic              cursor_en;
  logic [CW-1:0]     cursor_col;
  logic [AW-1:0]     cursor_row;
  logic [BW-1:0]     char_addr;
  logic [15:0]       char_data;
  logic [FAW-1:0]    font_addr;
  logic [FONT_W-1:0] font_data;
  logic              out_valid;
  logic [3:0]        color_index;

  text_render_pipe #(
    .COLS(COLS), .ROWS(ROWS), .FONT_W(FONT_W), .FONT_H(FONT_H),
    .BLINK_FRAMES(BLINK), .CURSOR_LINES(CURL), .ATTR_BLINK(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid), .i_pix_x(pix_x), .i_pix_y(pix_y),
    .i_frame_start(frame_start), .i_scroll_row(scroll_row), .i_cursor_en(cursor_en),
    .i_cursor_col(cursor_col), .i_cursor_row(cursor_row), .o_char_addr(char_addr),
    .i_char_data(char_data), .o_font_addr(font_addr), .i_font_data(font_data),
    .o_out_valid(out_valid), .o_color_index(color_index)
  );

  always #5 clk = ~clk;

  logic [15:0] buf_mem [0:COLS*ROWS-1];
  logic [7:0]  font_mem [0:256*FONT_H-1];

  always @(posedge clk) begin
    char_data <= buf_mem[char_addr];
    font_data <= font_mem[font_addr];
  end

  int checks = 0;
  int failures = 0;

  // Model state
  int         m_frames;
  int         m_shadow;
  logic [4:0] exp_q[$];
  int         addr_q[$];
  logic [3:0] col_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {valid, colour} a pixel should produce, from the cell/glyph rules.
  function automatic logic [4:0] model_pix(input logic v, input int x, input int y,
                                           input logic cen, input int ccol, input int crow);
    int col, srow, line, brow, gidx;
    logic [15:0] d;
    logic [7:0]  g;
    logic [3:0]  fg, bg;
    logic        ph, b;
    if (!v) return 5'd0;
    col  = x / FONT_W;
    srow = y / FONT_H;
    if (col >= COLS || srow >= ROWS) return {1'b1, 4'd0};
    ph   = ((m_frames / BLINK) % 2) == 1;
    brow = (srow + m_shadow) % ROWS;
    d    = buf_mem[brow * COLS + col];
    line = y % FONT_H;
    gidx = int'(d[7:0]) * FONT_H + line;
    g    = font_mem[gidx];
    b    = g[FONT_W - 1 - (x % FONT_W)];
    fg   = d[11:8];
    bg   = {1'b0, d[14:12]};
    if (cen && col == ccol && srow == crow && line >= FONT_H - CURL && !ph) return {1'b1, fg};
    if (b) return {1'b1, (d[15] && ph) ? bg : fg};
    return {1'b1, bg};
  endfunction

  function automatic int model_addr(input logic v, input int x, input int y);
    int col, srow;
    if (!v) return -1;
    col  = x / FONT_W;
    srow = y / FONT_H;
    if (col >= COLS || srow >= ROWS) return 0;
    return ((srow + m_shadow) % ROWS) * COLS + col;
  endfunction

  // One clock: drive a pixel, advance, compare outputs due at this edge.
  task automatic step(input logic v, input int x, input int y, input logic fs, input int scr,
                      input logic cen, input int ccol, input int crow);
    logic [4:0] e;
    int a;
    pix_valid   = v;
    pix_x       = 11'(x);
    pix_y       = 11'(y);
    frame_start = fs;
    scroll_row  = AW'(scr);
    cursor_en   = cen;
    cursor_col  = CW'(ccol);
    cursor_row  = AW'(crow);
    exp_q.push_back(model_pix(v, x, y, cen, ccol, crow));
    addr_q.push_back(model_addr(v, x, y));
    @(posedge clk);
    #1;
    if (fs) begin
      m_frames++;
      m_shadow = (scr >= ROWS) ? 0 : scr;
    end
    e = exp_q.pop_front();
    chk("out_valid", 32'(out_valid), 32'(e[4]));
    chk("color_index", 32'(color_index), 32'(e[3:0]));
    col_log.push_back(color_index);
    a = addr_q.pop_front();
    if (a >= 0) chk("char_addr", 32'(char_addr), a);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic frames(input int n, input int scr);
    repeat (n) step(1'b0, 0, 0, 1'b1, scr, 1'b0, 0, 0);
  endtask

  task automatic probe(input logic v, input int x, input int y, input logic cen,
                       input int ccol, input int crow, output logic ov, output logic [3:0] oc);
    step(v, x, y, 1'b0, 0, cen, ccol, crow);
    idle(4);
    ov = out_valid;
    oc = color_index;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_color", 32'(color_index), 32'd0);
    chk("rst_char_addr", 32'(char_addr), 32'd0);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    cursor_en   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_frames = 0;
    m_shadow = 0;
    exp_q.delete();
    addr_q.delete();
    repeat (4) exp_q.push_back(5'd0);
    addr_q.push_back(-1);
  endtask

  task automatic random_run(input int n);
    logic v, fs, cen;
    int x, y, ccol, crow;
    for (int i = 0; i < n; i++) begin
      v    = ($urandom_range(0, 9) != 0);
      x    = $urandom_range(0, 700);
      y    = $urandom_range(0, 430);
      fs   = ($urandom_range(0, 7) == 0);
      cen  = $urandom_range(0, 1) == 1;
      ccol = ($urandom_range(0, 1) == 1) ? x / FONT_W : $urandom_range(0, COLS - 1);
      crow = ($urandom_range(0, 1) == 1) ? y / FONT_H : $urandom_range(0, ROWS - 1);
      if (crow > 31) crow = 31;
      step(v, x, y, fs, $urandom_range(0, 31), cen, ccol, crow);
    end
  endtask

  logic       ov;
  logic [3:0] oc;
  logic [3:0] exp1 [8];

  initial begin
    rst         = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    frame_start = 1'b0;
    scroll_row  = '0;
    cursor_en   = 1'b0;
    cursor_col  = '0;
    cursor_row  = '0;
    for (int i = 0; i < COLS * ROWS; i++) buf_mem[i] = 16'($urandom);
    for (int i = 0; i < 256 * FONT_H; i++) font_mem[i] = 8'($urandom);
    buf_mem[0] = 16'h1F41;
    font_mem[8'h41 * FONT_H] = 8'h18;
    exp1 = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1};

    // 1: glyph 'A' line 0 across the first cell
    do_reset();
    col_log.delete();
    for (int x = 0; x < 8; x++) step(1'b1, x, 0, 1'b0, 0, 1'b0, 0, 0);
    idle(4);
    for (int k = 0; k < 8; k++) chk("t1_pixel", 32'(col_log[k + 4]), 32'(exp1[k]));

    // 2: scroll and wrap
    frames(1, 3);
    step(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    idle(1);
    chk("t2_addr_scroll", 32'(char_addr), 32'd240);
    step(1'b1, 0, 22 * FONT_H, 1'b0, 0, 1'b0, 0, 0);
    idle(1);
    chk("t2_addr_wrap", 32'(char_addr), 32'd0);
    step(1'b1, 0, 21 * FONT_H, 1'b0, 0, 1'b0, 0, 0);
    idle(1);
    chk("t2_addr_last_row", 32'(char_addr), 32'd1920);
    idle(4);
    frames(1, 27);
    probe(1'b1, 9, 17, 1'b0, 0, 0, ov, oc);

    // 3: border and invalid pixel
    probe(1'b1, 640, 0, 1'b0, 0, 0, ov, oc);
    chk("t3_border_valid", 32'(ov), 32'd1);
    chk("t3_border_color", 32'(oc), 32'd0);
    probe(1'b0, 16, 16, 1'b0, 0, 0, ov, oc);
    chk("t3_invalid", 32'(ov), 32'd0);
    step(1'b1, 24, 0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 24, 0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b1, 32, 0, 1'b0, 0, 1'b0, 0, 0);
    idle(4);

    // 4: attribute blink
    do_reset();
    buf_mem[1] = {8'hC2, 8'h80};
    font_mem[8'h80 * FONT_H] = 8'hFF;
    probe(1'b1, 8, 0, 1'b0, 0, 0, ov, oc);
    chk("t4_frame0", 32'(oc), 32'd2);
    frames(31, 0);
    probe(1'b1, 9, 0, 1'b0, 0, 0, ov, oc);
    chk("t4_frame31", 32'(oc), 32'd2);
    frames(1, 0);
    probe(1'b1, 10, 0, 1'b0, 0, 0, ov, oc);
    chk("t4_frame32", 32'(oc), 32'd4);
    frames(32, 0);
    probe(1'b1, 11, 0, 1'b0, 0, 0, ov, oc);
    chk("t4_frame64", 32'(oc), 32'd2);

    // 5: underline cursor at (5,2), blank glyph lines
    buf_mem[2 * COLS + 5] = {8'h1E, 8'h90};
    for (int l = 13; l < 16; l++) font_mem[8'h90 * FONT_H + l] = 8'h00;
    probe(1'b1, 43, 2 * FONT_H + 14, 1'b1, 5, 2, ov, oc);
    chk("t5_line14_on", 32'(oc), 32'hE);
    probe(1'b1, 40, 2 * FONT_H + 15, 1'b1, 5, 2, ov, oc);
    chk("t5_line15_on", 32'(oc), 32'hE);
    probe(1'b1, 47, 2 * FONT_H + 13, 1'b1, 5, 2, ov, oc);
    chk("t5_line13", 32'(oc), 32'h1);
    frames(32, 0);
    probe(1'b1, 43, 2 * FONT_H + 14, 1'b1, 5, 2, ov, oc);
    chk("t5_line14_off", 32'(oc), 32'h1);
    probe(1'b1, 40, 2 * FONT_H + 15, 1'b1, 5, 2, ov, oc);
    chk("t5_line15_off", 32'(oc), 32'h1);

    // Randomized streams with frame pulses, scroll and cursor changes
    random_run(700);

    // 6: reset mid-stream, then recovery
    do_reset();
    random_run(250);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
